hazard_unit_np: RTL and testbench

- Parametrised hazard/stall/flush controller for an N-stage in-order RV32I pipeline. It generalises the two-stage hazard unit to NUM_STAGES stages with per-register stall/flush vectors.
- Adds three behaviours the two-stage unit lacks:
  - a squash state that discards an in-flight stale instruction fetch after a redirect;
  - a halt drain/halted state machine;
  - saturating stall and redirect performance counters.
- Sits between fetch, the resolve stage (last stage: branch, jump, memory, halt) and the pipeline registers.

---
 rtl/hazard_unit_np_pkg.sv | 16 +
 rtl/hazard_unit_np_if.sv | 33 +++
 rtl/hazard_unit_np_sat_counter.sv | 19 +
 rtl/hazard_unit_np.sv | 124 ++++++++++++
 tb/tb_hazard_unit_np.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_np_pkg.sv
// Shared types and legal parameter ranges for the N-stage hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hazard_state_t;

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 5;
  localparam int CNT_W_MIN      = 8;
  localparam int CNT_W_MAX      = 64;

endpackage

// File: rtl/hazard_unit_np_if.sv
// Handshake bundle between fetch/resolve stages, pipeline registers and the
// hazard controller. The hazard unit uses the slave side.
interface hazard_unit_np_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32
);
  logic                    i_ram_busy;
  logic                    iren;
  logic                    d_ram_busy;
  logic                    dren;
  logic                    dwen;
  logic                    jump;
  logic                    branch;
  logic                    mispredict;
  logic                    halt;
  logic                    pc_en;
  logic                    npc_sel;
  logic [NUM_STAGES-2:0]   stall;
  logic [NUM_STAGES-2:0]   flush;
  logic                    halted;
  logic [CNT_W-1:0]        stall_cycles;
  logic [CNT_W-1:0]        redirect_count;

  modport master (
    output i_ram_busy, iren, d_ram_busy, dren, dwen, jump, branch, mispredict, halt,
    input  pc_en, npc_sel, stall, flush, halted, stall_cycles, redirect_count
  );

  modport slave (
    input  i_ram_busy, iren, d_ram_busy, dren, dwen, jump, branch, mispredict, halt,
    output pc_en, npc_sel, stall, flush, halted, stall_cycles, redirect_count
  );
endinterface

// File: rtl/hazard_unit_np_sat_counter.sv
// Unsigned event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] ONE = W'(1);

  // count qualifying cycles, holding at the maximum value
  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end
endmodule

// File: rtl/hazard_unit_np.sv
// Stall/flush/redirect controller for an N-stage in-order pipeline, with
// stale-fetch squashing, halt drain and saturating performance counters.
module hazard_unit_np
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32
) (
  input logic             CLK,
  input logic             RST,
  hazard_unit_np_if.slave bus
);
  localparam int SW = NUM_STAGES - 1;
  localparam logic [SW-1:0] ALL   = '1;
  localparam logic [SW-1:0] FIRST = SW'(1);

  hazard_state_t state, state_nxt;

  logic          d_busy, i_busy, redir;
  logic          pc_en, npc_sel, halted;
  logic [SW-1:0] stall, flush;
  logic          redir_acc, stall_inc;
  logic          unused_branch;

  assign d_busy        = (bus.dren | bus.dwen) & bus.d_ram_busy;
  assign i_busy        = bus.iren & bus.i_ram_busy;
  assign redir         = bus.mispredict | bus.jump;
  assign unused_branch = bus.branch;

  // state register; reset always returns to RUN
  always_ff @(posedge CLK) begin
    if (RST)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // next-state and output decode, priority d_busy > halt > redir > i_busy
  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    npc_sel   = 1'b0;
    stall     = '0;
    flush     = '0;
    halted    = 1'b0;
    redir_acc = 1'b0;
    if (RST) begin
      flush     = ALL;
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (d_busy) begin
            stall = ALL;
          end else if (bus.halt) begin
            flush     = ALL;
            state_nxt = i_busy ? DRAIN : HALTED;
          end else if (redir) begin
            pc_en     = 1'b1;
            npc_sel   = 1'b1;
            flush     = ALL;
            redir_acc = 1'b1;
            state_nxt = i_busy ? SQUASH : RUN;
          end else if (i_busy) begin
            flush = FIRST;
          end else begin
            pc_en = 1'b1;
          end
        end
        SQUASH: begin
          // the stale fetch word must never enter register 0
          flush     = FIRST;
          state_nxt = bus.i_ram_busy ? SQUASH : RUN;
          if (d_busy) begin
            stall = ALL & ~FIRST;
          end else if (bus.halt) begin
            flush     = ALL;
            state_nxt = DRAIN;
          end else if (redir) begin
            pc_en     = 1'b1;
            npc_sel   = 1'b1;
            flush     = ALL;
            redir_acc = 1'b1;
            state_nxt = SQUASH;
          end
        end
        DRAIN: begin
          flush = ALL;
          if (!bus.i_ram_busy)
            state_nxt = HALTED;
        end
        HALTED: begin
          flush  = ALL;
          halted = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  assign stall_inc = !pc_en && ((state == RUN) || (state == SQUASH));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (redir_acc),
    .count (bus.redirect_count)
  );

  assign bus.pc_en   = pc_en;
  assign bus.npc_sel = npc_sel;
  assign bus.stall   = stall;
  assign bus.flush   = flush;
  assign bus.halted  = halted;
endmodule

// File: tb/tb_hazard_unit_np.sv
// Directed table-driven bench for hazard_unit_np (3 stages), with a second
// CNT_W=8 instance sharing the stimulus for counter saturation.
module tb_hazard_unit_np;
  logic clk = 1'b0;
  logic rst, iren, irb, dren, dwen, drb, jump, branch, mis, halt;

  int total  = 0;
  int passed = 0;

  hazard_unit_np_if #(.NUM_STAGES(3), .CNT_W(32)) bus_a ();
  hazard_unit_np_if #(.NUM_STAGES(3), .CNT_W(8))  bus_b ();

  hazard_unit_np #(.NUM_STAGES(3), .CNT_W(32)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  hazard_unit_np #(.NUM_STAGES(3), .CNT_W(8))  dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  assign bus_a.i_ram_busy = irb;   assign bus_b.i_ram_busy = irb;
  assign bus_a.iren       = iren;  assign bus_b.iren       = iren;
  assign bus_a.d_ram_busy = drb;   assign bus_b.d_ram_busy = drb;
  assign bus_a.dren       = dren;  assign bus_b.dren       = dren;
  assign bus_a.dwen       = dwen;  assign bus_b.dwen       = dwen;
  assign bus_a.jump       = jump;  assign bus_b.jump       = jump;
  assign bus_a.branch     = branch; assign bus_b.branch    = branch;
  assign bus_a.mispredict = mis;   assign bus_b.mispredict = mis;
  assign bus_a.halt       = halt;  assign bus_b.halt       = halt;

  always #5 clk = ~clk;

  // in  = {rst, iren, i_ram_busy, dren, dwen, d_ram_busy, jump, branch, mispredict, halt}
  // exp = {pc_en, npc_sel, stall[1:0], flush[1:0], halted}
  // sc/rc = counter values seen before the edge closing the cycle (-1: don't check)
  typedef struct {
    string      name;
    logic [9:0] in;
    logic [6:0] exp;
    int         sc;
    int         rc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [9:0] i, input logic [6:0] e,
                     input int sc, input int rc);
    vec_t v;
    v.name = n; v.in = i; v.exp = e; v.sc = sc; v.rc = rc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [9:0] i);
    {rst, iren, irb, dren, dwen, drb, jump, branch, mis, halt} = i;
  endtask

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    else
      passed++;
  endtask

  function automatic logic [6:0] outs_a();
    return {bus_a.pc_en, bus_a.npc_sel, bus_a.stall, bus_a.flush, bus_a.halted};
  endfunction

  initial begin
    drive(10'b0);

    // reset
    add("rst0",        10'b1000000000, 7'b0000110, -1, -1);
    add("rst1",        10'b1000000000, 7'b0000110,  0,  0);
    add("rst2",        10'b1000000000, 7'b0000110,  0,  0);
    add("idle",        10'b0000000000, 7'b1000000,  0,  0);
    // fetch stall for 4 cycles
    add("fstall0",     10'b0110000000, 7'b0000010,  0,  0);
    add("fstall1",     10'b0110000000, 7'b0000010,  1,  0);
    add("fstall2",     10'b0110000000, 7'b0000010,  2,  0);
    add("fstall3",     10'b0110000000, 7'b0000010,  3,  0);
    add("fetch_ok",    10'b0100000000, 7'b1000000,  4,  0);
    // mispredict with fetch in flight, then squash
    add("redir_mis",   10'b0110000010, 7'b1100110,  4,  0);
    add("squash0",     10'b0110000000, 7'b0000010,  4,  1);
    add("squash1",     10'b0110000000, 7'b0000010,  5,  1);
    add("squash_last", 10'b0100000000, 7'b0000010,  6,  1);
    add("run_back",    10'b0100000000, 7'b1000000,  7,  1);
    // data busy beats jump and fetch stall
    add("dbusy_jmp0",  10'b0111011000, 7'b0011000,  7,  1);
    add("dbusy_jmp1",  10'b0111011000, 7'b0011000,  8,  1);
    add("jmp_fires",   10'b0111001000, 7'b1100110,  9,  1);
    add("squash_dbsy", 10'b0111010000, 7'b0010010,  9,  2);
    add("squash_end",  10'b0100000000, 7'b0000010, 10,  2);
    add("run_idle",    10'b0000000000, 7'b1000000, 11,  2);
    // halt beats mispredict; drain then halted
    add("halt_mis",    10'b0110000011, 7'b0000110, 11,  2);
    add("drain_busy",  10'b0110000010, 7'b0000110, 12,  2);
    add("drain_done",  10'b0100000000, 7'b0000110, 12,  2);
    add("halted_mis",  10'b0000000010, 7'b0000111, 12,  2);
    add("halted_jmp",  10'b0110001000, 7'b0000111, 12,  2);
    add("rst_halted",  10'b1000000000, 7'b0000110, 12,  2);
    add("run_after",   10'b0000000000, 7'b1000000,  0,  0);
    // reset aborts a squash
    add("redir_sq",    10'b0110000010, 7'b1100110,  0,  0);
    add("rst_in_sq",   10'b1110000000, 7'b0000110,  0,  1);
    add("run_not_sq",  10'b0010000000, 7'b1000000,  0,  0);
    // jump without fetch busy, store stall, redirect inside squash
    add("jmp_plain",   10'b0000001000, 7'b1100110,  0,  0);
    add("idle2",       10'b0000000000, 7'b1000000,  0,  1);
    add("store_busy",  10'b0000110000, 7'b0011000,  0,  1);
    add("redir_sq2",   10'b0110000010, 7'b1100110,  1,  1);
    add("sq_rejump",   10'b0110001000, 7'b1100110,  1,  2);
    add("sq_exit",     10'b0000000000, 7'b0000010,  1,  3);
    add("idle3",       10'b0000000000, 7'b1000000,  2,  3);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      @(negedge clk);
      chk(vecs[i].name, 64'(outs_a()), 64'(vecs[i].exp));
      if (vecs[i].sc >= 0)
        chk({vecs[i].name, "_sc"}, 64'(bus_a.stall_cycles), 64'(vecs[i].sc));
      if (vecs[i].rc >= 0)
        chk({vecs[i].name, "_rc"}, 64'(bus_a.redirect_count), 64'(vecs[i].rc));
      chk({vecs[i].name, "_excl"}, 64'(bus_a.stall & bus_a.flush), 64'(0));
      chk({vecs[i].name, "_npc"}, 64'(bus_a.npc_sel & ~bus_a.pc_en), 64'(0));
      @(posedge clk);
      #1;
    end

    // saturation of the 8-bit counters over 300 fetch-stall cycles
    drive(10'b1000000000);
    @(posedge clk);
    #1;
    drive(10'b0110000000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 254) chk("sat_pre", 64'(bus_b.stall_cycles), 64'(254));
      if (i == 255) chk("sat_hit", 64'(bus_b.stall_cycles), 64'(255));
      @(posedge clk);
    end
    #1;
    chk("sat_hold", 64'(bus_b.stall_cycles), 64'(255));
    chk("wide_300", 64'(bus_a.stall_cycles), 64'(300));
    chk("sat_rc",   64'(bus_b.redirect_count), 64'(0));

    // halt straight into HALTED, then reset back to RUN
    drive(10'b0000000001);
    @(posedge clk);
    #1;
    drive(10'b0000000000);
    @(negedge clk);
    chk("b_halted", 64'(bus_b.halted), 64'(1));
    chk("b_halt_pc", 64'(bus_b.pc_en), 64'(0));
    @(posedge clk);
    #1;
    drive(10'b1000000000);
    @(posedge clk);
    #1;
    drive(10'b0000000000);
    @(negedge clk);
    chk("b_unhalt", 64'(bus_b.halted), 64'(0));
    chk("b_run_pc", 64'(bus_b.pc_en), 64'(1));
    chk("b_sc_clr", 64'(bus_b.stall_cycles), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
